pc_unit: RTL

//   Fetch-stage program counter of the P7 pipelined MIPS CPU. Consumes the D-stage branch

---
 rtl/mips_pkg.sv | 22 ++
 rtl/pc_unit_if.sv | 32 +++
 rtl/npc_sel.sv | 41 ++++
 rtl/pc_unit.sv | 67 ++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - fetch-stage PC constants, next-PC select encoding and fetch address check.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6ffc;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_EPC,
    SEL_EXC
  } npc_sel_t;

  function automatic logic fetch_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IMEM_LO) || (addr > IMEM_HI);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - D-stage redirect inputs and F-stage PC outputs of the fetch unit.
interface pc_unit_if;

  logic        stall;
  logic        is_bj_D;
  logic        br_taken_D;
  logic        br_D;
  logic [31:0] br_target_D;
  logic        j_D;
  logic [31:0] j_target_D;
  logic        jr_D;
  logic [31:0] jr_target_D;
  logic        exc_req;
  logic        eret_D;
  logic [31:0] epc;
  logic [31:0] pc_F;
  logic        bd_F;
  logic        adel_F;

  modport master (
    output stall, is_bj_D, br_taken_D, br_D, br_target_D, j_D, j_target_D,
           jr_D, jr_target_D, exc_req, eret_D, epc,
    input  pc_F, bd_F, adel_F
  );

  modport slave (
    input  stall, is_bj_D, br_taken_D, br_D, br_target_D, j_D, j_target_D,
           jr_D, jr_target_D, exc_req, eret_D, epc,
    output pc_F, bd_F, adel_F
  );

endinterface

// File: rtl/npc_sel.sv
// rtl/npc_sel.sv - next-PC priority encoder: exc_req > eret > jr > j > taken branch > PC+4.
module npc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        exc_req,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic        jr_D,
  input  logic [31:0] jr_target_D,
  input  logic        j_D,
  input  logic [31:0] j_target_D,
  input  logic        br_D,
  input  logic        br_taken_D,
  input  logic [31:0] br_target_D,
  output npc_sel_t    sel,
  output logic [31:0] npc
);

  always_comb begin
    sel = SEL_SEQ;
    npc = pc + 32'd4;
    if (exc_req) begin
      sel = SEL_EXC;
      npc = EXC_PC;
    end else if (eret_D) begin
      sel = SEL_EPC;
      npc = epc;
    end else if (jr_D) begin
      sel = SEL_JR;
      npc = jr_target_D;
    end else if (j_D) begin
      sel = SEL_J;
      npc = j_target_D;
    end else if (br_D && br_taken_D) begin
      sel = SEL_BR;
      npc = br_target_D;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - F-stage PC/delay-slot registers with stall gating.
// PC_ALIGN_CHECK_EN: when defined, registers a fetch address error flag (adel_F).
module pc_unit
  import mips_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  npc_sel_t    sel;
  logic [31:0] npc;
  logic [31:0] pc_q;
  logic        bd_q;
  logic        redirect;
  logic        update;

  npc_sel u_npc_sel (
    .pc          (pc_q),
    .exc_req     (bus.exc_req),
    .eret_D      (bus.eret_D),
    .epc         (bus.epc),
    .jr_D        (bus.jr_D),
    .jr_target_D (bus.jr_target_D),
    .j_D         (bus.j_D),
    .j_target_D  (bus.j_target_D),
    .br_D        (bus.br_D),
    .br_taken_D  (bus.br_taken_D),
    .br_target_D (bus.br_target_D),
    .sel         (sel),
    .npc         (npc)
  );

  // Flush and eret redirect even while the hazard unit is stalling.
  assign redirect = (sel == SEL_EXC) || (sel == SEL_EPC);
  assign update   = redirect || !bus.stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else if (update) begin
      pc_q <= npc;
      bd_q <= redirect ? 1'b0 : bus.is_bj_D;
    end
  end

  assign bus.pc_F = pc_q;
  assign bus.bd_F = bd_q;

`ifdef PC_ALIGN_CHECK_EN
  logic adel_q;

  always_ff @(posedge clk) begin
    if (reset || bus.exc_req) begin
      adel_q <= 1'b0;
    end else if (update) begin
      adel_q <= fetch_bad(npc);
    end
  end

  assign bus.adel_F = adel_q;
`else
  assign bus.adel_F = 1'b0;
`endif

endmodule
